// File: rtl/udp_reg_slave_pkg.sv
// Shared ring constants: bus widths, block tags, the unmapped-read value and the address split helpers.
package udp_reg_slave_pkg;

  localparam int UDP_REG_ADDR_WIDTH  = 12;
  localparam int CPCI_NF2_DATA_WIDTH = 32;

  localparam logic [7:0] BLOCK_TAG_SLAVE0 = 8'h01;
  localparam logic [7:0] BLOCK_TAG_SLAVE1 = 8'h02;

  // Also returned by the ring master when nobody acknowledges a request.
  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] UNMAPPED_RD_DATA = 32'hdead_beef;

  function automatic logic [UDP_REG_ADDR_WIDTH-1:0] addr_tag(
    input logic [UDP_REG_ADDR_WIDTH-1:0] addr,
    input int                            reg_w
  );
    return addr >> reg_w;
  endfunction

  function automatic logic [UDP_REG_ADDR_WIDTH-1:0] addr_idx(
    input logic [UDP_REG_ADDR_WIDTH-1:0] addr,
    input int                            reg_w
  );
    return addr & ((UDP_REG_ADDR_WIDTH'(1) << reg_w) - UDP_REG_ADDR_WIDTH'(1));
  endfunction

endpackage

// File: rtl/udp_reg_slave_cntr.sv
// One wrapping 32-bit event counter; a load beats a clear-on-read, which beats a plain increment.
module udp_reg_cntr
  import udp_reg_slave_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           inc,
  input  logic                           load,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] load_data,
  input  logic                           clr_on_rd,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] value
);

  logic [CPCI_NF2_DATA_WIDTH-1:0] value_q, value_d;

  // Next-state selection by event priority
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_data;
    end else if (clr_on_rd) begin
      value_d = inc ? CPCI_NF2_DATA_WIDTH'(1) : CPCI_NF2_DATA_WIDTH'(0);
    end else if (inc) begin
      value_d = value_q + CPCI_NF2_DATA_WIDTH'(1);
    end else begin
      value_d = value_q;
    end
  end

  // Counter storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/udp_reg_slave.sv
// One register-ring stage: claims requests tagged BLOCK_TAG, serves software registers and
// event counters, and forwards all other ring traffic with a single cycle of latency.
module udp_reg_slave
  import udp_reg_slave_pkg::*;
#(
  parameter int BLOCK_TAG         = 'h01,
  parameter int REG_ADDR_WIDTH    = 4,
  parameter int NUM_SW_REGS       = 4,
  parameter int NUM_CNTR_REGS     = 4,
  parameter int RESET_ON_READ     = 0,
  parameter int UDP_REG_SRC_WIDTH = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     reg_req_in,
  input  logic                                     reg_ack_in,
  input  logic                                     reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]            reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0]           reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]             reg_src_in,
  output logic                                     reg_req_out,
  output logic                                     reg_ack_out,
  output logic                                     reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]            reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0]           reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]             reg_src_out,
  output logic [NUM_SW_REGS*CPCI_NF2_DATA_WIDTH-1:0] sw_regs,
  input  logic [NUM_CNTR_REGS-1:0]                 cntr_inc
);

  localparam int AW = UDP_REG_ADDR_WIDTH;
  localparam int DW = CPCI_NF2_DATA_WIDTH;

  if (NUM_SW_REGS + NUM_CNTR_REGS > 2**REG_ADDR_WIDTH) begin : g_bad_map
    $error("udp_reg_slave: register map does not fit in REG_ADDR_WIDTH index bits");
  end

  logic          hit_s, wr_s, rd_s;
  logic [AW-1:0] idx_s;
  logic [DW-1:0] rd_data_s;
  logic [DW-1:0] sw_q [NUM_SW_REGS];
  logic [DW-1:0] cntr_val_s [NUM_CNTR_REGS];

  logic                         req_q, ack_q, rd_wr_L_q;
  logic                         req_d, ack_d, rd_wr_L_d;
  logic [AW-1:0]                addr_q, addr_d;
  logic [DW-1:0]                data_q, data_d;
  logic [UDP_REG_SRC_WIDTH-1:0] src_q, src_d;

  assign hit_s = reg_req_in && !reg_ack_in &&
                 (addr_tag(reg_addr_in, REG_ADDR_WIDTH) == AW'(BLOCK_TAG));
  assign idx_s = addr_idx(reg_addr_in, REG_ADDR_WIDTH);
  assign wr_s  = hit_s && !reg_rd_wr_L_in;
  assign rd_s  = hit_s &&  reg_rd_wr_L_in;

  // Read mux over pre-update register and counter values
  always_comb begin
    rd_data_s = UNMAPPED_RD_DATA;
    for (int i = 0; i < NUM_SW_REGS; i++) begin
      rd_data_s = (idx_s == AW'(i)) ? sw_q[i] : rd_data_s;
    end
    for (int i = 0; i < NUM_CNTR_REGS; i++) begin
      rd_data_s = (idx_s == AW'(NUM_SW_REGS + i)) ? cntr_val_s[i] : rd_data_s;
    end
  end

  // Next ring cycle: idle bus, pass-through, or acknowledged hit
  always_comb begin
    req_d     = 1'b0;
    ack_d     = 1'b0;
    rd_wr_L_d = 1'b0;
    addr_d    = '0;
    data_d    = '0;
    src_d     = '0;
    if (reg_req_in) begin
      req_d     = 1'b1;
      ack_d     = reg_ack_in || hit_s;
      rd_wr_L_d = reg_rd_wr_L_in;
      addr_d    = reg_addr_in;
      data_d    = rd_s ? rd_data_s : reg_data_in;
      src_d     = reg_src_in;
    end else begin
      req_d     = 1'b0;
    end
  end

  // Ring output pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q     <= 1'b0;
      ack_q     <= 1'b0;
      rd_wr_L_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      src_q     <= '0;
    end else begin
      req_q     <= req_d;
      ack_q     <= ack_d;
      rd_wr_L_q <= rd_wr_L_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      src_q     <= src_d;
    end
  end

  // Software register storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SW_REGS; i++) sw_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SW_REGS; i++) begin
        if (wr_s && (idx_s == AW'(i))) sw_q[i] <= reg_data_in;
      end
    end
  end

  for (genvar g = 0; g < NUM_SW_REGS; g++) begin : g_sw_flat
    assign sw_regs[g*DW +: DW] = sw_q[g];
  end

  for (genvar g = 0; g < NUM_CNTR_REGS; g++) begin : g_cntr
    udp_reg_cntr u_cntr (
      .clk       (clk),
      .reset     (reset),
      .inc       (cntr_inc[g]),
      .load      (wr_s && (idx_s == AW'(NUM_SW_REGS + g))),
      .load_data (reg_data_in),
      .clr_on_rd ((RESET_ON_READ != 0) && rd_s && (idx_s == AW'(NUM_SW_REGS + g))),
      .value     (cntr_val_s[g])
    );
  end

  assign reg_req_out     = req_q;
  assign reg_ack_out     = ack_q;
  assign reg_rd_wr_L_out = rd_wr_L_q;
  assign reg_addr_out    = addr_q;
  assign reg_data_out    = data_q;
  assign reg_src_out     = src_q;

endmodule

// File: tb/tb_udp_reg_slave.sv
// Directed bench: two instances on the same ring inputs, one plain and one with clear-on-read counters.
module tb_udp_reg_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i, ack_i, rd_i;
  logic [11:0] addr_i;
  logic [31:0] data_i;
  logic [1:0]  src_i;
  logic [3:0]  inc_i;

  logic         req_a, ack_a, rd_a, req_b, ack_b, rd_b;
  logic [11:0]  addr_a, addr_b;
  logic [31:0]  data_a, data_b;
  logic [1:0]   src_a, src_b;
  logic [127:0] sw_a, sw_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  udp_reg_slave #(.RESET_ON_READ(0)) u_dut_a (
    .clk(clk), .reset(reset), .reg_req_in(req_i), .reg_ack_in(ack_i), .reg_rd_wr_L_in(rd_i),
    .reg_addr_in(addr_i), .reg_data_in(data_i), .reg_src_in(src_i),
    .reg_req_out(req_a), .reg_ack_out(ack_a), .reg_rd_wr_L_out(rd_a), .reg_addr_out(addr_a),
    .reg_data_out(data_a), .reg_src_out(src_a), .sw_regs(sw_a), .cntr_inc(inc_i)
  );

  udp_reg_slave #(.RESET_ON_READ(1)) u_dut_b (
    .clk(clk), .reset(reset), .reg_req_in(req_i), .reg_ack_in(ack_i), .reg_rd_wr_L_in(rd_i),
    .reg_addr_in(addr_i), .reg_data_in(data_i), .reg_src_in(src_i),
    .reg_req_out(req_b), .reg_ack_out(ack_b), .reg_rd_wr_L_out(rd_b), .reg_addr_out(addr_b),
    .reg_data_out(data_b), .reg_src_out(src_b), .sw_regs(sw_b), .cntr_inc(inc_i)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One ring cycle: drive on the falling edge, return 1 time unit after the capturing edge
  task automatic cyc(input logic req, input logic ack, input logic rd, input logic [11:0] addr,
                     input logic [31:0] data, input logic [1:0] src, input logic [3:0] inc);
    @(negedge clk);
    req_i = req; ack_i = ack; rd_i = rd; addr_i = addr; data_i = data; src_i = src; inc_i = inc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] inc);
    cyc(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 2'd0, inc);
  endtask

  initial begin
    reset = 1'b0;
    req_i = 1'b0; ack_i = 1'b0; rd_i = 1'b0; addr_i = 12'h0; data_i = 32'h0; src_i = 2'd0; inc_i = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {127'h0, req_a}, 128'h0);
    check("rst_data", {96'h0, data_a}, 128'h0);
    check("rst_sw", sw_a, 128'h0);
    @(negedge clk);
    reset = 1'b1;

    // software register write then read-back
    cyc(1'b1, 1'b0, 1'b0, 12'h012, 32'h1234_5678, 2'd1, 4'h0);
    check("wr_ack", {127'h0, ack_a}, 128'h1);
    check("wr_data", {96'h0, data_a}, {96'h0, 32'h1234_5678});
    check("wr_sw", sw_a, {32'h0, 32'h1234_5678, 32'h0, 32'h0});
    cyc(1'b1, 1'b0, 1'b1, 12'h012, 32'h0, 2'd3, 4'h0);
    check("rd_ack", {127'h0, ack_a}, 128'h1);
    check("rd_data", {96'h0, data_a}, {96'h0, 32'h1234_5678});
    check("rd_src", {126'h0, src_a}, 128'h3);
    check("rd_rdwr", {127'h0, rd_a}, 128'h1);

    // foreign tag forwarded untouched
    cyc(1'b1, 1'b0, 1'b1, 12'h020, 32'hcafe_f00d, 2'd2, 4'h0);
    check("fwd_ack", {127'h0, ack_a}, 128'h0);
    check("fwd_data", {96'h0, data_a}, {96'h0, 32'hcafe_f00d});
    check("fwd_addr", {116'h0, addr_a}, {116'h0, 12'h020});
    check("fwd_sw", sw_a, {32'h0, 32'h1234_5678, 32'h0, 32'h0});

    // counter 1 (index 5): five increments on an idle bus
    for (int i = 0; i < 5; i++) idle(4'b0010);
    check("idle_req", {127'h0, req_a}, 128'h0);
    check("idle_data", {96'h0, data_a}, 128'h0);
    cyc(1'b1, 1'b0, 1'b1, 12'h015, 32'h0, 2'd0, 4'b0010);
    check("cnt5_a", {96'h0, data_a}, 128'h5);
    check("cnt5_b", {96'h0, data_b}, 128'h5);
    cyc(1'b1, 1'b0, 1'b1, 12'h015, 32'h0, 2'd0, 4'h0);
    check("cnt_noclr_a", {96'h0, data_a}, 128'h6);
    check("cnt_clrinc_b", {96'h0, data_b}, 128'h1);
    cyc(1'b1, 1'b0, 1'b1, 12'h015, 32'h0, 2'd0, 4'h0);
    check("cnt_hold_a", {96'h0, data_a}, 128'h6);
    check("cnt_clr_b", {96'h0, data_b}, 128'h0);

    // counter 0 (index 4): wrap, then write beats a simultaneous increment
    cyc(1'b1, 1'b0, 1'b0, 12'h014, 32'hffff_ffff, 2'd0, 4'h0);
    check("cwr_ack", {127'h0, ack_a}, 128'h1);
    idle(4'b0001);
    cyc(1'b1, 1'b0, 1'b1, 12'h014, 32'h0, 2'd0, 4'h0);
    check("wrap_a", {96'h0, data_a}, 128'h0);
    check("wrap_b", {96'h0, data_b}, 128'h0);
    cyc(1'b1, 1'b0, 1'b0, 12'h014, 32'h0000_0010, 2'd0, 4'b0001);
    cyc(1'b1, 1'b0, 1'b1, 12'h014, 32'h0, 2'd0, 4'h0);
    check("wr_win_a", {96'h0, data_a}, 128'h10);
    check("wr_win_b", {96'h0, data_b}, 128'h10);

    // unmapped index
    cyc(1'b1, 1'b0, 1'b1, 12'h01f, 32'h0, 2'd0, 4'h0);
    check("unmap_ack", {127'h0, ack_a}, 128'h1);
    check("unmap_data", {96'h0, data_a}, {96'h0, 32'hdead_beef});
    cyc(1'b1, 1'b0, 1'b0, 12'h01f, 32'h5555_5555, 2'd0, 4'h0);
    check("unmap_wr_ack", {127'h0, ack_a}, 128'h1);
    check("unmap_wr_sw", sw_a, {32'h0, 32'h1234_5678, 32'h0, 32'h0});

    // matching tag already acked upstream: no side effect
    cyc(1'b1, 1'b1, 1'b0, 12'h012, 32'h0bad_0bad, 2'd1, 4'h0);
    check("acked_ack", {127'h0, ack_a}, 128'h1);
    check("acked_data", {96'h0, data_a}, {96'h0, 32'h0bad_0bad});
    check("acked_sw", sw_a, {32'h0, 32'h1234_5678, 32'h0, 32'h0});
    cyc(1'b1, 1'b0, 1'b1, 12'h012, 32'h0, 2'd0, 4'h0);
    check("acked_rd", {96'h0, data_a}, {96'h0, 32'h1234_5678});

    // asynchronous reset while a request is on the output
    check("pre_rst_req", {127'h0, req_a}, 128'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_req", {127'h0, req_a}, 128'h0);
    check("mid_rst_ack", {127'h0, ack_a}, 128'h0);
    check("mid_rst_data", {96'h0, data_a}, 128'h0);
    check("mid_rst_sw", sw_a, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 12'h014, 32'h0, 2'd0, 4'h0);
    check("post_rst_cnt", {96'h0, data_a}, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
